// File: rtl/uart_fifo_pkg.sv
// Shared types and constants for the outfifo-to-UART word serializer.
// SER_CHECKSUM_EN (define) enables the trailing XOR checksum byte in fifo_word_serializer.
package uart_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_SEND = 3'd3,
        ST_CSUM = 3'd4
    } ser_state_e;

    localparam int              BYTE_W    = 8;
    localparam logic [BYTE_W-1:0] CSUM_SEED = 8'h00;

    // Number of whole bytes needed to carry a ww-bit word.
    function automatic int num_bytes(input int ww);
        return (ww + BYTE_W - 1) / BYTE_W;
    endfunction

endpackage

// File: rtl/word_byte_shifter.sv
// Byte-granular shift register: loads a WW-bit word zero-padded to whole bytes,
// presents the low byte and shifts right by one byte per shift strobe.
module word_byte_shifter
    import uart_fifo_pkg::*;
#(
    parameter int WW = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WW-1:0]     din,
    output logic [BYTE_W-1:0] byte_o
);

    localparam int NB = num_bytes(WW);
    localparam int SW = NB * BYTE_W;

    logic [SW-1:0] sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            // Padding bits above WW are cleared here so the last byte goes out with zeros.
            sh_d          = '0;
            sh_d[WW-1:0]  = din;
        end else if (shift) begin
            sh_d = sh_q >> BYTE_W;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sh_q <= '0;
        else      sh_q <= sh_d;
    end

    assign byte_o = sh_q[BYTE_W-1:0];

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops packed Wc x W words from the outfifo and streams them LSB byte first to uart_tx.
// Define SER_CHECKSUM_EN to append an XOR checksum byte after each word's data bytes.
module fifo_word_serializer
    import uart_fifo_pkg::*;
#(
    parameter int W  = 6,
    parameter int Wc = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [W*Wc-1:0]   fifo_dout,
    output logic              fifo_rd_en,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [15:0]       words_sent
);

    localparam int WW    = W * Wc;
    localparam int NB    = num_bytes(WW);
    localparam int IDX_W = $clog2(NB + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    ser_state_e       state_q, state_d;
    logic             fifo_rd_en_q, fifo_rd_en_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic [15:0]      words_sent_q, words_sent_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             sh_load, sh_shift;
    logic [BYTE_W-1:0] byte_out;
    logic             hs;

`ifdef SER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif

    word_byte_shifter #(.WW(WW)) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .load   (sh_load),
        .shift  (sh_shift),
        .din    (fifo_dout),
        .byte_o (byte_out)
    );

    assign hs = tx_valid_q & tx_ready;

    always_comb begin
        state_d      = state_q;
        fifo_rd_en_d = 1'b0;
        tx_valid_d   = tx_valid_q;
        words_sent_d = words_sent_q;
        idx_d        = idx_q;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
`ifdef SER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d      = ST_RD;
                    fifo_rd_en_d = 1'b1;
                end
            end
            ST_RD: state_d = ST_CAP;
            ST_CAP: begin
                // fifo_dout is valid now, one cycle after the read strobe.
                sh_load    = 1'b1;
                idx_d      = '0;
                tx_valid_d = 1'b1;
                state_d    = ST_SEND;
`ifdef SER_CHECKSUM_EN
                csum_d     = CSUM_SEED;
`endif
            end
            ST_SEND: begin
                if (hs) begin
                    sh_shift = 1'b1;
`ifdef SER_CHECKSUM_EN
                    csum_d   = csum_q ^ byte_out;
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef SER_CHECKSUM_EN
                        state_d      = ST_CSUM;
`else
                        state_d      = ST_IDLE;
                        tx_valid_d   = 1'b0;
                        words_sent_d = words_sent_q + 16'd1;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef SER_CHECKSUM_EN
            ST_CSUM: begin
                if (hs) begin
                    state_d      = ST_IDLE;
                    tx_valid_d   = 1'b0;
                    words_sent_d = words_sent_q + 16'd1;
                end
            end
`endif
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            fifo_rd_en_q <= 1'b0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            words_sent_q <= '0;
            idx_q        <= '0;
`ifdef SER_CHECKSUM_EN
            csum_q       <= CSUM_SEED;
`endif
        end else begin
            state_q      <= state_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            words_sent_q <= words_sent_d;
            idx_q        <= idx_d;
`ifdef SER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

`ifdef SER_CHECKSUM_EN
    assign tx_data = (state_q == ST_CSUM) ? csum_q : byte_out;
`else
    assign tx_data = byte_out;
`endif

    assign fifo_rd_en = fifo_rd_en_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Scoreboard bench: two serializers (24-bit and 20-bit words) fed from queue-backed FIFO models.
module tb_fifo_word_serializer;

    localparam int NB0 = 3;
    localparam int NB1 = 3;
`ifdef SER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, tx_ready = 1'b0;
    logic        fe0 = 1'b1, fe1 = 1'b1;
    logic [23:0] fd0 = '0;
    logic [19:0] fd1 = '0;
    logic        rd0, rd1, tv0, tv1, busy0, busy1;
    logic [7:0]  td0, td1;
    logic [15:0] ws0, ws1;

    logic [23:0] fq0[$];
    logic [19:0] fq1[$];
    logic [8:0]  exp0[$], exp1[$];

    int total = 0, bad = 0, cyc = 0, mode = 3, scnt = 0;
    int ws_exp0 = 0, ws_exp1 = 0, rd_cnt0 = 0, rd_cnt1 = 0, words0 = 0, words1 = 0;
    logic stall0 = 1'b0, stall1 = 1'b0;
    logic [7:0] hold0 = '0, hold1 = '0;

    fifo_word_serializer #(.W(6), .Wc(4)) u0 (
        .clk(clk), .rst(rst), .fifo_empty(fe0), .fifo_dout(fd0), .fifo_rd_en(rd0),
        .tx_data(td0), .tx_valid(tv0), .tx_ready(tx_ready), .busy(busy0), .words_sent(ws0)
    );

    fifo_word_serializer #(.W(5), .Wc(4)) u1 (
        .clk(clk), .rst(rst), .fifo_empty(fe1), .fifo_dout(fd1), .fifo_rd_en(rd1),
        .tx_data(td1), .tx_valid(tv1), .tx_ready(tx_ready), .busy(busy1), .words_sent(ws1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
        logic [31:0] s;
        s = w >> (8 * i);
        return s[7:0];
    endfunction

    task automatic push0(input logic [23:0] w);
        logic [7:0] cs, b;
        cs = 8'h00;
        for (int i = 0; i < NB0; i++) begin
            b  = byte_of({8'h0, w}, i);
            cs = cs ^ b;
            exp0.push_back({(i == NB0 - 1) && !CS, b});
        end
        if (CS) exp0.push_back({1'b1, cs});
        fq0.push_back(w);
        words0++;
    endtask

    task automatic push1(input logic [19:0] w);
        logic [7:0] cs, b;
        cs = 8'h00;
        for (int i = 0; i < NB1; i++) begin
            b  = byte_of({12'h0, w}, i);
            cs = cs ^ b;
            exp1.push_back({(i == NB1 - 1) && !CS, b});
        end
        if (CS) exp1.push_back({1'b1, cs});
        fq1.push_back(w);
        words1++;
    endtask

    // FIFO models: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (rd0 && fq0.size() > 0) fd0 <= fq0.pop_front();
        if (rd1 && fq1.size() > 0) fd1 <= fq1.pop_front();
        fe0 <= (fq0.size() == 0);
        fe1 <= (fq1.size() == 0);
    end

    // tx_ready patterns: 0 always ready, 1 ten-cycle stall per byte, 2 random, 3 manual
    always @(posedge clk) begin
        #1;
        case (mode)
            0: tx_ready = 1'b1;
            1: begin
                if (tx_ready) begin
                    tx_ready = 1'b0;
                    scnt = 0;
                end else if (tv0) begin
                    if (scnt == 9) tx_ready = 1'b1;
                    else scnt++;
                end
            end
            2: tx_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            if (rd0) rd_cnt0++;
            if (stall0) begin
                check("stall_vld0", tv0, 1);
                check("stall_dat0", td0, hold0);
            end
            stall0 = tv0 && !tx_ready;
            hold0  = td0;
            if (tv0 && tx_ready) begin
                if (exp0.size() == 0) check("extra_byte0", exp0.size(), 1);
                else begin
                    logic [8:0] e;
                    e = exp0.pop_front();
                    check("byte0", td0, e[7:0]);
                    check("ws_hs0", ws0, ws_exp0);
                    if (e[8]) ws_exp0++;
                end
            end
        end else stall0 = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (rd1) rd_cnt1++;
            if (stall1) begin
                check("stall_vld1", tv1, 1);
                check("stall_dat1", td1, hold1);
            end
            stall1 = tv1 && !tx_ready;
            hold1  = td1;
            if (tv1 && tx_ready) begin
                if (exp1.size() == 0) check("extra_byte1", exp1.size(), 1);
                else begin
                    logic [8:0] e;
                    e = exp1.pop_front();
                    check("byte1", td1, e[7:0]);
                    check("ws_hs1", ws1, ws_exp1);
                    if (e[8]) ws_exp1++;
                end
            end
        end else stall1 = 1'b0;
    end

    task automatic wait_idle0(input int lim);
        int n = 0;
        @(negedge clk);
        while ((exp0.size() != 0 || busy0 || fq0.size() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("idle0_left", exp0.size(), 0);
        check("idle0_busy", busy0, 0);
        check("idle0_ws", ws0, ws_exp0);
        check("idle0_rd", rd_cnt0, words0);
    endtask

    task automatic wait_idle1(input int lim);
        int n = 0;
        @(negedge clk);
        while ((exp1.size() != 0 || busy1 || fq1.size() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("idle1_left", exp1.size(), 0);
        check("idle1_busy", busy1, 0);
        check("idle1_ws", ws1, ws_exp1);
        check("idle1_rd", rd_cnt1, words1);
    endtask

    initial begin
        int q, n, t0;
        #1 rst = 1'b0;
        #2;
        check("rst_rd", rd0, 0);
        check("rst_vld", tv0, 0);
        check("rst_dat", td0, 0);
        check("rst_busy", busy0, 0);
        check("rst_ws", ws0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // nothing to read: outputs stay quiet
        q = 0;
        repeat (50) begin
            @(negedge clk);
            if (rd0 || tv0 || busy0) q++;
        end
        check("idle_quiet", q, 0);

        // single word, always ready, first byte three cycles after empty falls
        mode = 0;
        @(posedge clk); #1;
        push0(24'h123456);
        n = 0;
        do begin @(negedge clk); n++; end while (fe0 && n < 20);
        t0 = cyc;
        n = 0;
        while (!tv0 && n < 20) begin @(negedge clk); n++; end
        check("latency", cyc - t0, 3);
        wait_idle0(200);
        check("ws_first", ws0, 1 + 0 * CS);

        // same word with long stalls on every byte
        mode = 1;
        push0(24'h123456);
        wait_idle0(1000);

        // 20-bit lanes: top byte padded with zeros
        mode = 0;
        push1(20'hABCDE);
        wait_idle1(200);
        check("ws_pad", ws1, 1);

        // back-to-back random words with random ready on both
        mode = 2;
        for (int i = 0; i < 5; i++) push0(24'($urandom));
        for (int i = 0; i < 3; i++) push1(20'($urandom));
        wait_idle0(3000);
        wait_idle1(3000);

        // reset while byte 1 is stalled, then a fresh word from byte 0
        mode = 3;
        @(posedge clk); #1 tx_ready = 1'b1;
        push0(24'hC0FFEE);
        n = 0;
        while (!(tv0 && tx_ready) && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_vld", tv0, 0);
        check("mid_rst_dat", td0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_rd", rd0, 0);
        check("mid_rst_ws", ws0, 0);
        exp0.delete();
        ws_exp0 = 0;
        ws_exp1 = 0;
        @(posedge clk); #1 rst = 1'b1;
        tx_ready = 1'b1;
        push0(24'hA5B6C7);
        wait_idle0(200);
        check("ws_after_rst", ws0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
